// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave. A grant is held until the owner drops cyc.
// Define WB_ARBITER_RTY_EN to forward slave retry responses to the owner. By default rty is tied low.
module wb_arbiter #(
    parameter int NUM_MASTERS = 5,
    parameter int DW          = 32,
    parameter int AW          = 32
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]      wbm_we_i,
    input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
    output logic [DW-1:0]               wbm_dat_o,
    output logic [NUM_MASTERS-1:0]      wbm_ack_o,
    output logic [NUM_MASTERS-1:0]      wbm_err_o,
    output logic [NUM_MASTERS-1:0]      wbm_rty_o,
    output logic [AW-1:0]               wbs_adr_o,
    output logic [DW-1:0]               wbs_dat_o,
    output logic [DW/8-1:0]             wbs_sel_o,
    output logic                        wbs_we_o,
    output logic                        wbs_cyc_o,
    output logic                        wbs_stb_o,
    output logic [2:0]                  wbs_cti_o,
    output logic [1:0]                  wbs_bte_o,
    input  logic [DW-1:0]               wbs_dat_i,
    input  logic                        wbs_ack_i,
    input  logic                        wbs_err_i,
    input  logic                        wbs_rty_i
);
    localparam int IW = $clog2(NUM_MASTERS);
    localparam int SW = DW / 8;

    // Handshake: a transfer is offered while cyc & stb are high. It completes on the cycle
    // the slave raises ack (or err/rty). The arbiter only routes these signals and never
    // stalls or terminates a transfer itself.

    logic          active;
    logic [IW-1:0] owner;
    logic [IW-1:0] last;

    logic          arb_edge;
    logic          found;
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;

    assign arb_edge = !active || !wbm_cyc_i[owner];

    // The scan starts just after the last grant, so a releasing owner only wins when it is alone.
    always_comb begin
        found = 1'b0;
        pick  = last;
        idx   = last;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = IW'((int'(last) + i) % NUM_MASTERS);
            if (!found && wbm_cyc_i[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            active <= 1'b0;
            owner  <= '0;
            last   <= IW'(NUM_MASTERS - 1);
        end else if (arb_edge) begin
            if (found) begin
                active <= 1'b1;
                owner  <= pick;
                last   <= pick;
            end else begin
                active <= 1'b0;
            end
        end
    end

    assign wbs_cyc_o = active & wbm_cyc_i[owner];
    assign wbs_stb_o = active & wbm_stb_i[owner];
    assign wbs_we_o  = wbm_we_i[owner];
    assign wbs_adr_o = wbm_adr_i[int'(owner)*AW +: AW];
    assign wbs_dat_o = wbm_dat_i[int'(owner)*DW +: DW];
    assign wbs_sel_o = wbm_sel_i[int'(owner)*SW +: SW];
    assign wbs_cti_o = wbm_cti_i[int'(owner)*3 +: 3];
    assign wbs_bte_o = wbm_bte_i[int'(owner)*2 +: 2];

    assign wbm_dat_o = wbs_dat_i;

    always_comb begin
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;
        if (active) begin
            wbm_ack_o[owner] = wbs_ack_i;
            wbm_err_o[owner] = wbs_err_i;
`ifdef WB_ARBITER_RTY_EN
            wbm_rty_o[owner] = wbs_rty_i;
`endif
        end
    end

`ifndef WB_ARBITER_RTY_EN
    logic unused_rty;
    assign unused_rty = wbs_rty_i;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a queue-based round-robin model.
module tb_wb_arbiter;
    localparam int NM = 5;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [NM*AW-1:0] adr;
    logic [NM*DW-1:0] dat;
    logic [NM*SW-1:0] sel;
    logic [NM-1:0]    we, cyc, stb;
    logic [NM*3-1:0]  cti;
    logic [NM*2-1:0]  bte;
    logic [DW-1:0]    s_dat;
    logic             s_ack, s_err, s_rty;

    logic [DW-1:0]    wbm_dat_o;
    logic [NM-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [AW-1:0]    wbs_adr_o;
    logic [DW-1:0]    wbs_dat_o;
    logic [SW-1:0]    wbs_sel_o;
    logic             wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [2:0]       wbs_cti_o;
    logic [1:0]       wbs_bte_o;

    wb_arbiter #(.NUM_MASTERS(NM), .DW(DW), .AW(AW)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .wbm_adr_i(adr), .wbm_dat_i(dat), .wbm_sel_i(sel),
        .wbm_we_i(we), .wbm_cyc_i(cyc), .wbm_stb_i(stb),
        .wbm_cti_i(cti), .wbm_bte_i(bte),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o),
        .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
        .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
        .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
        .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // prio_q holds master indices in current priority order. On a grant, the list is
    // rotated so the winner goes last. This keeps the cyclic order.
    bit m_active = 1'b0;
    int m_owner  = 0;
    int prio_q[$];
    bit cmp_en = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_owner  = 0;
            prio_q.delete();
            for (int k = 0; k < NM; k++) prio_q.push_back(k);
        end else if (!m_active || !cyc[m_owner]) begin
            int win;
            win = -1;
            foreach (prio_q[i]) if (win < 0 && cyc[prio_q[i]]) win = prio_q[i];
            if (win >= 0) begin
                while (prio_q[0] != win) prio_q.push_back(prio_q.pop_front());
                prio_q.push_back(prio_q.pop_front());
                m_active = 1'b1;
                m_owner  = win;
            end else begin
                m_active = 1'b0;
            end
        end
    end

    logic [NM-1:0] e_ack, e_err, e_rty;

    always @(negedge clk) begin
        if (cmp_en) begin
            e_ack = '0;
            e_err = '0;
            e_rty = '0;
            if (m_active) begin
                e_ack[m_owner] = s_ack;
                e_err[m_owner] = s_err;
`ifdef WB_ARBITER_RTY_EN
                e_rty[m_owner] = s_rty;
`endif
            end
            check("cyc_o", wbs_cyc_o, m_active && cyc[m_owner]);
            check("stb_o", wbs_stb_o, m_active && stb[m_owner]);
            check("adr_o", wbs_adr_o, adr[m_owner*AW +: AW]);
            check("dat_o", wbs_dat_o, dat[m_owner*DW +: DW]);
            check("sel_o", wbs_sel_o, sel[m_owner*SW +: SW]);
            check("we_o",  wbs_we_o,  we[m_owner]);
            check("cti_o", wbs_cti_o, cti[m_owner*3 +: 3]);
            check("bte_o", wbs_bte_o, bte[m_owner*2 +: 2]);
            check("ack_o", wbm_ack_o, e_ack);
            check("err_o", wbm_err_o, e_err);
            check("rty_o", wbm_rty_o, e_rty);
            check("mdat_o", wbm_dat_o, s_dat);
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 2 time units after the rising edge. Outputs are sampled on the falling edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic [AW-1:0] mad(input int k);
        return AW'(32'h1000 * (k + 1));
    endfunction

    task automatic set_m(input int k, input bit c, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [2:0] ct);
        cyc[k] = c;
        stb[k] = c;
        we[k]  = w;
        adr[k*AW +: AW] = a;
        dat[k*DW +: DW] = d;
        sel[k*SW +: SW] = '1;
        cti[k*3 +: 3]   = ct;
        bte[k*2 +: 2]   = 2'b00;
    endtask

    task automatic clear_all();
        adr = '0; dat = '0; sel = '0; we = '0; cyc = '0; stb = '0; cti = '0; bte = '0;
        s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        tick(n);
        rst_n = 1'b1;
    endtask

    logic [3:0] exp_q[$];

    // ---------------- stimulus ----------------
    initial begin
        int g;
        clear_all();
        rst_n = 1'b0;
        tick(1);
        cmp_en = 1'b1;

        // Reset holds everything quiet even with requests and responses present.
        cyc = '1; stb = '1; s_ack = 1'b1; s_err = 1'b1; s_rty = 1'b1;
        @(negedge clk);
        check("rst_cyc", wbs_cyc_o, 1'b0);
        check("rst_ack", wbm_ack_o, 5'b00000);
        check("rst_err", wbm_err_o, 5'b00000);
        check("rst_rty", wbm_rty_o, 5'b00000);
        tick(1);
        clear_all();
        s_ack = 1'b1;
        rst_n = 1'b1;

        // Idle for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_cyc", wbs_cyc_o, 1'b0);
            check("idle_ack", wbm_ack_o, 5'b00000);
        end

        // Master 2 alone writes.
        tick(1);
        set_m(2, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 3'd0);
        @(negedge clk);
        check("m2_pre_cyc", wbs_cyc_o, 1'b0);
        check("m2_pre_ack", wbm_ack_o, 5'b00000);
        tick(1);
        @(negedge clk);
        check("m2_cyc", wbs_cyc_o, 1'b1);
        check("m2_adr", wbs_adr_o, 32'h100);
        check("m2_dat", wbs_dat_o, 32'hDEADBEEF);
        check("m2_we", wbs_we_o, 1'b1);
        check("m2_ack", wbm_ack_o, 5'b00100);
        check("model_owner_m2", m_owner, 2);
        tick(1);
        clear_all();
        @(negedge clk);
        check("m2_drop_cyc", wbs_cyc_o, 1'b0);

        // Masters 0, 1 and 4 request together right after reset.
        tick(1);
        do_reset(2);
        for (int k = 0; k < NM; k++) set_m(k, 1'b0, 1'b0, mad(k), 32'hA0 + k, 3'd0);
        cyc[0] = 1'b1; cyc[1] = 1'b1; cyc[4] = 1'b1;
        exp_q = '{4'd0, 4'd1, 4'd4};
        while (exp_q.size() > 0) begin
            g = int'(exp_q.pop_front());
            tick(1);
            @(negedge clk);
            check("rr_grant", wbs_adr_o, mad(g));
            check("rr_cyc", wbs_cyc_o, 1'b1);
            tick(2);
            @(negedge clk);
            check("rr_hold", wbs_adr_o, mad(g));
            tick(1);
            cyc[g] = 1'b0;
            @(negedge clk);
            check("rr_gap_cyc", wbs_cyc_o, 1'b0);
        end

        // Master 3 burst while master 1 waits.
        tick(1);
        set_m(3, 1'b1, 1'b0, mad(3), 32'h33, 3'd2);
        s_ack = 1'b1;
        tick(1);
        set_m(1, 1'b1, 1'b0, mad(1), 32'h11, 3'd0);
        for (int b = 0; b < 4; b++) begin
            cti[9 +: 3] = (b == 3) ? 3'd7 : 3'd2;
            adr[3*AW +: AW] = mad(3) + AW'(4 * b);
            @(negedge clk);
            check("burst_adr", wbs_adr_o, mad(3) + AW'(4 * b));
            check("burst_cti", wbs_cti_o, (b == 3) ? 3'd7 : 3'd2);
            check("burst_ack", wbm_ack_o, 5'b01000);
            tick(1);
        end
        cyc[3] = 1'b0;
        s_ack = 1'b0;
        @(negedge clk);
        check("burst_drop_cyc", wbs_cyc_o, 1'b0);
        tick(1);
        @(negedge clk);
        check("m1_after_burst", wbs_adr_o, mad(1));
        check("model_owner_m1", m_owner, 1);
        tick(1);
        clear_all();

        // Error and retry routing to master 0.
        tick(1);
        do_reset(2);
        set_m(0, 1'b1, 1'b0, mad(0), 32'h0, 3'd0);
        tick(1);
        s_err = 1'b1;
        s_rty = 1'b1;
        @(negedge clk);
        check("err_route", wbm_err_o, 5'b00001);
        check("err_noack", wbm_ack_o, 5'b00000);
`ifdef WB_ARBITER_RTY_EN
        check("rty_route", wbm_rty_o, 5'b00001);
`else
        check("rty_off", wbm_rty_o, 5'b00000);
`endif
        tick(1);
        clear_all();

        // Reset in the middle of a master 3 burst.
        tick(1);
        set_m(3, 1'b1, 1'b0, mad(3), 32'h33, 3'd2);
        tick(1);
        set_m(0, 1'b1, 1'b0, mad(0), 32'h0, 3'd2);
        set_m(2, 1'b1, 1'b0, mad(2), 32'h22, 3'd2);
        s_ack = 1'b1;
        @(negedge clk);
        check("mid_owner3", wbs_adr_o, mad(3));
        tick(1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_pre_rst_cyc", wbs_cyc_o, 1'b1);
        tick(1);
        @(negedge clk);
        check("mid_rst_cyc", wbs_cyc_o, 1'b0);
        check("mid_rst_ack", wbm_ack_o, 5'b00000);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        @(negedge clk);
        check("post_rst_m0", wbs_adr_o, mad(0));
        check("post_rst_ack", wbm_ack_o, 5'b00001);
        tick(1);
        clear_all();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            tick(1);
            rst_n = ($urandom_range(0, 199) != 0);
            for (int k = 0; k < NM; k++) begin
                if (cyc[k]) begin
                    if ($urandom_range(0, 5) == 0) cyc[k] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    cyc[k] = 1'b1;
                end
                stb[k] = cyc[k] & ($urandom_range(0, 3) != 0);
                we[k]  = 1'($urandom_range(0, 1));
                adr[k*AW +: AW] = $urandom;
                dat[k*DW +: DW] = $urandom;
                sel[k*SW +: SW] = SW'($urandom_range(0, 15));
                cti[k*3 +: 3]   = 3'($urandom_range(0, 7));
                bte[k*2 +: 2]   = 2'($urandom_range(0, 3));
            end
            s_dat = $urandom;
            s_ack = 1'($urandom_range(0, 1));
            s_err = ($urandom_range(0, 7) == 0);
            s_rty = ($urandom_range(0, 7) == 0);
        end
        tick(1);
        rst_n = 1'b1;
        tick(2);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
